// File: rtl/seg_disp_ctrl.sv
// Four-digit common-anode 7-segment scan controller with tear-free
// frame-aligned updates, decimal points, leading-zero blanking and blink.
module seg_disp_ctrl #(
  parameter int SCAN_CNT     = 50_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        wr_vld,
  output logic        wr_rdy,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        wr_blank_lz,
  input  logic [3:0]  wr_blink,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CNT - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic          pend_q, pend_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_blz_q, pend_blz_d;
  logic [3:0]    pend_blink_q, pend_blink_d;
  logic [15:0]   act_data_q, act_data_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic          act_blz_q, act_blz_d;
  logic [3:0]    act_blink_q, act_blink_d;
  logic [7:0]    seg_q, seg_d;
  logic          rdy_q, rdy_d;
  logic          fdone_q, fdone_d;
  logic          wrap_s;
  logic          bnd_s;

  function automatic logic [7:0] hex_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      4'hF: code = 8'h8E;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Full segment pattern for one digit slot; blink overrides blanking, blanking keeps the dp.
  function automatic logic [7:0] digit_pattern(
    input logic [1:0]  idx,
    input logic [15:0] data,
    input logic [3:0]  dp,
    input logic        blz,
    input logic [3:0]  blink,
    input logic        phase
  );
    logic [3:0] nib;
    logic       blank;
    logic [7:0] code;
    logic [7:0] pat;
    case (idx)
      2'd0: begin nib = data[3:0];   blank = 1'b0; end
      2'd1: begin nib = data[7:4];   blank = (data[15:4] == 12'h000); end
      2'd2: begin nib = data[11:8];  blank = (data[15:8] == 8'h00); end
      2'd3: begin nib = data[15:12]; blank = (data[15:12] == 4'h0); end
      default: begin nib = 4'h0; blank = 1'b0; end
    endcase
    code = hex_code(nib);
    if (phase && blink[idx]) begin
      pat = 8'hFF;
    end else if (blz && blank) begin
      pat = {~dp[idx], 7'h7F};
    end else begin
      pat = {~dp[idx], code[6:0]};
    end
    return pat;
  endfunction

  // Scan counter, digit rotation and blink frame counter.
  always_comb begin
    wrap_s  = (cnt_q == CNT_MAX);
    bnd_s   = wrap_s && (idx_q == 2'd3);
    cnt_d   = wrap_s ? {CW{1'b0}} : cnt_q + CW'(1);
    idx_d   = wrap_s ? idx_q + 2'd1 : idx_q;
    sel_d   = wrap_s ? {sel_q[2:0], sel_q[3]} : sel_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    if (bnd_s) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = {FW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end else begin
      frm_d = frm_q;
    end
  end

  // Write handshake: a commit and a capture are exclusive because capture needs pend_q low.
  always_comb begin
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blz_d   = pend_blz_q;
    pend_blink_d = pend_blink_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blz_d    = act_blz_q;
    act_blink_d  = act_blink_q;
    if (bnd_s && pend_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_blz_d   = pend_blz_q;
      act_blink_d = pend_blink_q;
      pend_d      = 1'b0;
    end else if (wr_vld && !pend_q) begin
      pend_data_d  = wr_data;
      pend_dp_d    = wr_dp;
      pend_blz_d   = wr_blank_lz;
      pend_blink_d = wr_blink;
      pend_d       = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    rdy_d   = ~pend_d;
    fdone_d = (cnt_d == CNT_MAX) && (idx_d == 2'd3);
    seg_d   = digit_pattern(idx_d, act_data_d, act_dp_d, act_blz_d, act_blink_d, phase_d);
  end

  // State and output registers.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt_q        <= {CW{1'b0}};
      idx_q        <= 2'd0;
      sel_q        <= 4'b1110;
      frm_q        <= {FW{1'b0}};
      phase_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_data_q  <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_blz_q   <= 1'b0;
      pend_blink_q <= 4'h0;
      act_data_q   <= 16'h0000;
      act_dp_q     <= 4'h0;
      act_blz_q    <= 1'b0;
      act_blink_q  <= 4'h0;
      seg_q        <= 8'hFF;
      rdy_q        <= 1'b1;
      fdone_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blz_q   <= pend_blz_d;
      pend_blink_q <= pend_blink_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blz_q    <= act_blz_d;
      act_blink_q  <= act_blink_d;
      seg_q        <= seg_d;
      rdy_q        <= rdy_d;
      fdone_q      <= fdone_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign wr_rdy     = rdy_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: directed scenarios plus random writes,
// checked every cycle against a frame-arithmetic reference model.
module tb_seg_disp_ctrl;
  localparam int SC = 4;
  localparam int BF = 2;
  localparam int FL = 4 * SC;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        wr_vld = 1'b0;
  logic        wr_rdy;
  logic [15:0] wr_data = 16'h0000;
  logic [3:0]  wr_dp = 4'h0;
  logic        wr_blank_lz = 1'b0;
  logic [3:0]  wr_blink = 4'h0;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  seg_disp_ctrl #(.SCAN_CNT(SC), .BLINK_FRAMES(BF)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank_lz(wr_blank_lz), .wr_blink(wr_blink),
    .sel(sel), .seg(seg), .frame_done(frame_done)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    int          vis;
    logic [15:0] d;
    logic [3:0]  dp;
    logic        blz;
    logic [3:0]  bl;
  } upd_t;

  upd_t        q[$];
  upd_t        act;
  logic [7:0]  tbl [16];
  int          k;
  int          last_t;
  int          last_vis;
  bit          have_last;
  int          ntx;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  function automatic bit rdy_model();
    return !(have_last && k >= last_t + 1 && k < last_vis);
  endfunction

  // Expected segment byte from the display rules, for state k.
  function automatic logic [7:0] seg_model();
    int idx;
    int phase;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [7:0]  code;
    logic        dpv;
    if (k == 0) return 8'hFF;
    idx   = (k / SC) % 4;
    phase = ((k / FL) / BF) % 2;
    if (phase == 1 && act.bl[idx]) return 8'hFF;
    upper = act.d >> (4 * idx);
    nib   = upper[3:0];
    code  = tbl[nib];
    dpv   = act.dp[idx];
    if (act.blz && idx != 0 && upper == 16'h0000) return {~dpv, 7'h7F};
    return {~dpv, code[6:0]};
  endfunction

  task automatic check();
    logic [3:0] exp_sel;
    while (q.size() > 0 && q[0].vis <= k) act = q.pop_front();
    exp_sel = ~(4'b0001 << ((k / SC) % 4));
    chk("sel", {12'h000, sel}, {12'h000, exp_sel});
    chk("seg", {8'h00, seg}, {8'h00, seg_model()});
    chk("wr_rdy", {15'h0000, wr_rdy}, {15'h0000, rdy_model()});
    chk("frame_done", {15'h0000, frame_done}, {15'h0000, (k % FL) == FL - 1});
  endtask

  task automatic cyc(input logic vld, input logic [15:0] d, input logic [3:0] dp,
                     input logic blz, input logic [3:0] bl);
    upd_t u;
    wr_vld = vld; wr_data = d; wr_dp = dp; wr_blank_lz = blz; wr_blink = bl;
    if (vld && rdy_model()) begin
      u.vis = FL * ((k + 1) / FL + 1);
      u.d = d; u.dp = dp; u.blz = blz; u.bl = bl;
      q.push_back(u);
      last_t = k; last_vis = u.vis; have_last = 1'b1; ntx++;
    end
    @(posedge sclk);
    k++;
    #1;
    check();
  endtask

  task automatic idle_until(input int target);
    while (k < target) cyc(1'b0, 16'h0000, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic model_reset();
    q.delete();
    act = '{0, 16'h0000, 4'h0, 1'b0, 4'h0};
    have_last = 1'b0; last_t = 0; last_vis = 0; k = 0;
  endtask

  initial begin
    int n0;
    int bound;
    int tgt;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    ntx = 0;
    model_reset();

    // Reset state, then idle scan for three frames.
    repeat (2) @(posedge sclk);
    #1;
    check();
    @(negedge sclk);
    s_rst_n = 1'b1;
    idle_until(48);

    // Hex letters with a decimal point on digit 2.
    cyc(1'b1, 16'h12AF, 4'b0100, 1'b0, 4'h0);
    chk("s2_rdy_drop", {15'h0000, wr_rdy}, 16'h0000);
    idle_until(last_vis + 9);
    chk("s2_digit2", {8'h00, seg}, 16'h0024);
    idle_until(last_vis + 13);
    chk("s2_digit3", {8'h00, seg}, 16'h00F9);

    // Leading-zero blanking.
    cyc(1'b1, 16'h0050, 4'h0, 1'b1, 4'h0);
    idle_until(last_vis + 5);
    chk("s3_digit1", {8'h00, seg}, 16'h0092);
    idle_until(last_vis + 13);
    chk("s3_digit3", {8'h00, seg}, 16'h00FF);
    cyc(1'b1, 16'h0000, 4'h0, 1'b1, 4'h0);
    idle_until(last_vis + 16);

    // Held request while pending, then a transfer exactly on a boundary cycle.
    cyc(1'b1, 16'h1111, 4'h0, 1'b0, 4'h0);
    n0 = ntx;
    bound = 0;
    while (ntx == n0 && bound < 100) begin
      cyc(1'b1, 16'h2222, 4'h1, 1'b0, 4'h0);
      bound++;
    end
    if (ntx == n0) begin
      checks++; failures++;
      $error("FAIL s4_held_timeout k=%0d observed=no_transfer expected=transfer", k);
    end
    wr_vld = 1'b0;
    idle_until(last_vis + 1);
    tgt = FL * (k / FL) + FL - 1;
    if (tgt <= k) tgt += FL;
    idle_until(tgt);
    cyc(1'b1, 16'h3456, 4'h0, 1'b0, 4'h0);
    chk("s4_bnd_pending", {15'h0000, wr_rdy}, 16'h0000);
    chk("s4_bnd_vis", last_vis[15:0], 16'(tgt + 1 + FL));
    idle_until(last_vis + 4);

    // Blink on digit 0 across several blink half-periods.
    cyc(1'b1, 16'h789A, 4'h0, 1'b0, 4'b0001);
    idle_until(last_vis + 6 * FL);

    // Random writes, biased toward leading zeros.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] rd;
      rd = 16'($urandom) >> ($urandom_range(0, 16));
      cyc(($urandom_range(0, 3) == 0), rd, 4'($urandom), 1'($urandom), 4'($urandom));
    end

    // Asynchronous reset mid-frame with an update pending.
    idle_until(last_vis + 5);
    cyc(1'b1, 16'hABCD, 4'hF, 1'b0, 4'h0);
    cyc(1'b0, 16'h0000, 4'h0, 1'b0, 4'h0);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("s6_rst_sel", {12'h000, sel}, 16'h000E);
    chk("s6_rst_seg", {8'h00, seg}, 16'h00FF);
    chk("s6_rst_rdy", {15'h0000, wr_rdy}, 16'h0001);
    model_reset();
    @(posedge sclk);
    @(negedge sclk);
    s_rst_n = 1'b1;
    check();
    idle_until(3 * FL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
